// File: rtl/alu_pkg.sv
// Shared ALU definitions: 4-bit operation codes (also used by the ALU control
// decoder) and small helpers that classify an op code.
package alu_pkg;

  // Logic operations
  localparam logic [3:0] NOTA   = 4'b0000;  // ~A
  localparam logic [3:0] NOTB   = 4'b0001;  // ~B
  localparam logic [3:0] ANDAB  = 4'b0010;  // A & B
  localparam logic [3:0] ORAB   = 4'b0011;  // A | B
  localparam logic [3:0] XORAB  = 4'b0100;  // A ^ B
  localparam logic [3:0] NANDAB = 4'b0101;  // ~(A & B)
  localparam logic [3:0] NORAB  = 4'b0110;  // ~(A | B)
  localparam logic [3:0] XNORAB = 4'b0111;  // ~(A ^ B)
  // Arithmetic operations (two's complement, modulo 2^WIDTH)
  localparam logic [3:0] ADDAB  = 4'b1000;  // A + B
  localparam logic [3:0] SUBAB  = 4'b1001;  // A - B
  localparam logic [3:0] SUBBA  = 4'b1010;  // B - A
  localparam logic [3:0] ADDNN  = 4'b1011;  // -(A + B)
  // Codes 4'b1100..4'b1111 are unused and reported as illegal.

  function automatic logic op_is_arith(input logic [3:0] op);
    return op[3] & ~op[2];
  endfunction

  function automatic logic op_is_illegal(input logic [3:0] op);
    return op[3] & op[2];
  endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU compute stage.
// Ports:
//   op      - 4-bit operation code (alu_pkg)
//   a, b    - WIDTH-bit operands
//   result  - WIDTH-bit result (0 for unused codes)
//   ovf     - signed overflow of an arithmetic op, 0 otherwise
//   illegal - op is an unused code
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             illegal
);

  // Two guard bits hold the exact value of every arithmetic op:
  // A+B needs WIDTH+1 bits, -(A+B) can reach +2^WIDTH and needs WIDTH+2.
  localparam int EW = WIDTH + 2;

  logic signed [EW-1:0] ea;
  logic signed [EW-1:0] eb;
  logic signed [EW-1:0] exact;

  always_comb begin
    // NOTE: every output is given a default first, so no path through the
    // case statement leaves a signal unassigned and infers a latch.
    ea      = {{2{a[WIDTH-1]}}, a};
    eb      = {{2{b[WIDTH-1]}}, b};
    exact   = '0;
    result  = '0;
    ovf     = 1'b0;
    illegal = op_is_illegal(op);

    case (op)
      NOTA:    result = ~a;
      NOTB:    result = ~b;
      ANDAB:   result = a & b;
      ORAB:    result = a | b;
      XORAB:   result = a ^ b;
      NANDAB:  result = ~(a & b);
      NORAB:   result = ~(a | b);
      XNORAB:  result = ~(a ^ b);
      ADDAB:   exact  = ea + eb;
      SUBAB:   exact  = ea - eb;
      SUBBA:   exact  = eb - ea;
      ADDNN:   exact  = -(ea + eb);
      default: result = '0;
    endcase

    // Overflow: the truncated result, sign-extended back, differs from the
    // exact value.
    if (op_is_arith(op)) begin
      result = exact[WIDTH-1:0];
      ovf    = (exact != {{2{exact[WIDTH-1]}}, exact[WIDTH-1:0]});
    end
  end

endmodule

// File: rtl/alu_exec.sv
// Two-stage pipelined ALU execute block with valid/ready handshakes.
// S1 registers the request (op, a, b); alu_core computes between S1 and S2;
// S2 registers result and flags and drives the outputs.
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - request handshake
//   in_op, in_a, in_b     - operation code and operands
//   out_valid/out_ready   - result handshake
//   out_result            - WIDTH-bit result
//   out_zero              - result is all zeros
//   out_ovf               - signed overflow (arithmetic ops only)
//   out_illegal           - op was an unused code
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic             out_illegal
);

  // Stage 1: request registers
  logic             s1_valid;
  logic [3:0]       s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  // Stage 2: result registers
  logic             s2_valid;
  logic [WIDTH-1:0] s2_result;
  logic             s2_zero;
  logic             s2_ovf;
  logic             s2_illegal;

  // Compute outputs
  logic [WIDTH-1:0] core_result;
  logic             core_ovf;
  logic             core_illegal;

  logic s2_load;     // S2 can take a new value this cycle
  logic s1_advance;  // S1 content moves into S2 this cycle
  logic accept;      // request accepted this cycle

  assign s2_load    = !s2_valid || out_ready;
  assign s1_advance = s1_valid && s2_load;
  assign in_ready   = !s1_valid || s1_advance;
  assign accept     = in_valid && in_ready;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op      (s1_op),
    .a       (s1_a),
    .b       (s1_b),
    .result  (core_result),
    .ovf     (core_ovf),
    .illegal (core_illegal)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the data registers are reset too: they drive outputs that must
  // read 0 after reset, and the cost is a handful of flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_op    <= in_op;
        s1_a     <= in_a;
        s1_b     <= in_b;
      end else if (s1_advance) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // S2 holds its content while stalled, keeping the outputs stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      s2_result  <= '0;
      s2_zero    <= 1'b0;
      s2_ovf     <= 1'b0;
      s2_illegal <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_result  <= core_result;
        s2_zero    <= (core_result == '0);
        s2_ovf     <= core_ovf;
        s2_illegal <= core_illegal;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign out_result  = s2_result;
  assign out_zero    = s2_zero;
  assign out_ovf     = s2_ovf;
  assign out_illegal = s2_illegal;

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: a scoreboard queue is filled with model
// results when requests are accepted and drained by a monitor when results
// are consumed; scenario tasks add direct checks on timing and handshakes.
module tb_alu_exec;
  import alu_pkg::*;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_ovf;
  logic             out_illegal;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  alu_exec #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_ovf     (out_ovf),
    .out_illegal (out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: 64-bit signed arithmetic, overflow by range check.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint v;
    e  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    v  = 0;
    case (op)
      4'd0:  e.result = ~a;
      4'd1:  e.result = ~b;
      4'd2:  e.result = a & b;
      4'd3:  e.result = a | b;
      4'd4:  e.result = a ^ b;
      4'd5:  e.result = ~(a & b);
      4'd6:  e.result = ~(a | b);
      4'd7:  e.result = ~(a ^ b);
      4'd8:  v = sa + sb;
      4'd9:  v = sa - sb;
      4'd10: v = sb - sa;
      4'd11: v = -(sa + sb);
      default: e.illegal = 1'b1;
    endcase
    if (op >= 4'd8 && op <= 4'd11) begin
      e.result = v[31:0];
      e.ovf    = (v > 64'sd2147483647) || (v < -64'sd2147483648);
    end
    e.zero = (e.result == '0);
    return e;
  endfunction

  // Monitor: compare each consumed result with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      exp_t e;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result: got result=%h with no request outstanding",
                 out_result);
      end else begin
        e = sbq.pop_front();
        if ({out_result, out_zero, out_ovf, out_illegal} !== e) begin
          bad++;
          $display("FAIL result: got res=%h z=%b o=%b i=%b want res=%h z=%b o=%b i=%b",
                   out_result, out_zero, out_ovf, out_illegal,
                   e.result, e.zero, e.ovf, e.illegal);
        end
      end
    end
  end

  // One clock cycle of stimulus; called at posedge+1, returns at posedge+1.
  task automatic cycle_drive(input logic v, input logic [3:0] op,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic rdy, output logic acc);
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    out_ready = rdy;
    @(negedge clk);
    acc = v && in_ready;
    if (acc) sbq.push_back(model(op, a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    logic acc;
    for (int i = 0; i < 20; i++) begin
      if (sbq.size() == 0 && !out_valid) break;
      cycle_drive(1'b0, 4'd0, '0, '0, 1'b1, acc);
    end
    total++;
    if (sbq.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL drain: pending=%0d out_valid=%b want pending=0 out_valid=0",
               sbq.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0 || {out_result, out_zero, out_ovf, out_illegal} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: valid=%b res=%h z=%b o=%b i=%b want all 0",
               out_valid, out_result, out_zero, out_ovf, out_illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0",
               in_ready, out_valid);
    end
  endtask

  task automatic test_latency();
    logic acc;
    cycle_drive(1'b1, ADDAB, 32'd7, 32'd5, 1'b1, acc);
    total++;
    if (acc !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL latency_first_edge: acc=%b out_valid=%b want 1/0", acc, out_valid);
    end
    cycle_drive(1'b0, 4'd0, '0, '0, 1'b1, acc);
    total++;
    if (out_valid !== 1'b1 || out_result !== 32'd12 || out_zero !== 1'b0 ||
        out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL latency_second_edge: valid=%b res=%h z=%b o=%b want 1/0000000c/0/0",
               out_valid, out_result, out_zero, out_ovf);
    end
    drain();
  endtask

  task automatic test_ops();
    logic        acc;
    logic [3:0]  ops [6] = '{ADDAB, SUBAB, SUBBA, ADDNN, NORAB, ADDNN};
    logic [31:0] as  [6] = '{32'h7FFFFFFF, 32'h1234, 32'd3, 32'd1, 32'd0, 32'h80000000};
    logic [31:0] bs  [6] = '{32'd1, 32'h1234, 32'd10, 32'd2, 32'd0, 32'h80000000};
    for (int i = 0; i < 6; i++)
      cycle_drive(1'b1, ops[i], as[i], bs[i], 1'b1, acc);
    // Every op code with random operands, back to back.
    for (int i = 0; i < 48; i++)
      cycle_drive(1'b1, 4'(i % 16), $urandom, $urandom, 1'b1, acc);
    drain();
  endtask

  task automatic test_backpressure();
    logic        acc;
    logic [3:0]  ops [3] = '{ADDAB, SUBAB, XORAB};
    logic [31:0] as  [3] = '{32'd100, 32'd200, 32'hF0F0F0F0};
    logic [31:0] bs  [3] = '{32'd1, 32'd2, 32'h0FF00FF0};
    logic [35:0] snap;
    logic        have_snap = 1'b0;
    int          k = 0;
    for (int c = 0; c < 5; c++) begin
      cycle_drive(1'b1, ops[k], as[k], bs[k], 1'b0, acc);
      if (acc && k < 2) k++;
      if (out_valid) begin
        if (!have_snap) begin
          snap      = {out_result, out_zero, out_ovf, out_illegal};
          have_snap = 1'b1;
        end else begin
          total++;
          if ({out_result, out_zero, out_ovf, out_illegal} !== snap) begin
            bad++;
            $display("FAIL stall_stable: got %h want %h",
                     {out_result, out_zero, out_ovf, out_illegal}, snap);
          end
        end
      end
    end
    total++;
    if (k != 2 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_accept: accepted=%0d in_ready=%b out_valid=%b want 2/0/1",
               k, in_ready, out_valid);
    end
    // Release: the third request is still presented and must get in.
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++)
      cycle_drive(1'b1, ops[2], as[2], bs[2], 1'b1, acc);
    total++;
    if (acc !== 1'b1) begin
      bad++;
      $display("FAIL release_accept: third request accepted=%b want 1", acc);
    end
    drain();
  endtask

  task automatic test_illegal();
    logic acc;
    cycle_drive(1'b1, 4'b1101, 32'hDEAD, 32'hBEEF, 1'b1, acc);
    cycle_drive(1'b1, ANDAB, 32'hFF00FF00, 32'h0FF00FF0, 1'b1, acc);
    total++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_result !== '0 ||
        out_zero !== 1'b1 || out_ovf !== 1'b0) begin
      bad++;
      $display("FAIL illegal_flags: valid=%b i=%b res=%h z=%b o=%b want 1/1/0/1/0",
               out_valid, out_illegal, out_result, out_zero, out_ovf);
    end
    for (logic [4:0] op = 5'd12; op < 5'd16; op++)
      cycle_drive(1'b1, op[3:0], $urandom, $urandom, 1'b1, acc);
    cycle_drive(1'b1, SUBAB, 32'd50, 32'd8, 1'b1, acc);
    drain();
  endtask

  task automatic test_back_to_back();
    logic acc;
    int   n_acc = 0;
    out_ready = 1'b0;
    cycle_drive(1'b1, ADDAB, 32'd1, 32'd1, 1'b0, acc);
    cycle_drive(1'b1, ADDAB, 32'd2, 32'd2, 1'b0, acc);
    // Pipeline full; consume and accept in the same cycle.
    cycle_drive(1'b1, ADDAB, 32'd3, 32'd3, 1'b1, acc);
    total++;
    if (acc !== 1'b1) begin
      bad++;
      $display("FAIL full_accept: in_ready=%b want 1 when full and out_ready=1", acc);
    end
    drain();
    // Random handshake stress.
    for (int i = 0; i < 300; i++) begin
      cycle_drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                  $urandom, 1'($urandom_range(0, 3) != 0), acc);
      if (acc) n_acc++;
    end
    total++;
    if (n_acc == 0) begin
      bad++;
      $display("FAIL stress_accept: accepted=%0d want >0", n_acc);
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    logic acc;
    cycle_drive(1'b1, ADDAB, 32'd11, 32'd22, 1'b0, acc);
    cycle_drive(1'b1, SUBAB, 32'd33, 32'd44, 1'b0, acc);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_inflight: out_valid=%b in_ready=%b want 0/1",
               out_valid, in_ready);
    end
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      cycle_drive(1'b0, 4'd0, '0, '0, 1'b1, acc);
      total++;
      if (out_valid !== 1'b0) begin
        bad++;
        $display("FAIL stale_result: out_valid=%b res=%h want no result",
                 out_valid, out_result);
      end
    end
    // Still functional after reset.
    cycle_drive(1'b1, XNORAB, 32'h0, 32'hFFFF0000, 1'b1, acc);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_latency();
    test_ops();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
